// File: rtl/mem_arbiter.sv
// Round-robin / fixed-priority arbiter sharing one registered-read RAM
// between the fetch port and the load/store port.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAP,
    WR_ISSUE,
    DONE
  } state_t;

  state_t r_state;
  logic   r_owner;
  logic   r_last;
  logic   w_any;
  logic   w_tie;
  logic   w_grant_d;

  // owner/last hold 1 for D, 0 for IF
  assign w_any     = if_req | d_req;
  assign w_tie     = if_req & d_req;
  assign w_grant_d = w_tie ? ((RR_EN != 0) ? ~r_last : 1'b1)
                           : d_req;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_wren <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner  <= w_grant_d;
            r_last   <= w_grant_d;
            mem_addr <= w_grant_d ? d_addr : if_addr;
            if (w_grant_d && d_we) begin
              mem_din  <= d_wdata;
              mem_wren <= 1'b1;
              r_state  <= WR_ISSUE;
            end else begin
              r_state  <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: r_state <= RD_CAP;
        RD_CAP: begin
          if (r_owner) begin
            d_rdata <= mem_dout;
            d_ack   <= 1'b1;
          end else begin
            if_rdata <= mem_dout;
            if_ack   <= 1'b1;
          end
          r_state <= DONE;
        end
        WR_ISSUE: begin
          mem_wren <= 1'b0;
          d_ack    <= 1'b1;
          r_state  <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
